// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: word RAM behind a Req/Ready handshake with LATENCY wait states.
// Optional DM_RESP_ERR_EN adds an Err output that flags illegal Membe lane masks.
module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [3:0]        Membe,
    input  logic              Sign,
    input  logic [31:0]       Wd,
    output logic              Ready,
    output logic [31:0]       Rd,
    output logic              Busy
`ifdef DM_RESP_ERR_EN
    ,
    output logic              Err
`endif
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic                r_wr, r_sign;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_be;
    logic [31:0]         r_wd;

    logic                c_wr, c_sign;
    logic [ADDR_W-1:0]   c_addr;
    logic [3:0]          c_be, be_eff;
    logic [31:0]         c_wd, old, merged, ld;
    logic                legal, bad, enter_resp, we;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: if (Req) begin
                cnt_nx   = LAT;
                state_nx = (LAT == 4'd0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = S_RESP;
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // With zero latency the commit edge is also the accept edge, so use live inputs in IDLE.
    assign c_wr       = (state == S_IDLE) ? Wr    : r_wr;
    assign c_sign     = (state == S_IDLE) ? Sign  : r_sign;
    assign c_addr     = (state == S_IDLE) ? Addr  : r_addr;
    assign c_be       = (state == S_IDLE) ? Membe : r_be;
    assign c_wd       = (state == S_IDLE) ? Wd    : r_wd;
    assign enter_resp = (state_nx == S_RESP) && (state != S_RESP);

    always_comb begin
        case (c_be)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
    end

`ifdef DM_RESP_ERR_EN
    assign bad = ~legal;
`else
    assign bad = 1'b0;
`endif
    assign be_eff = legal ? c_be : 4'b1111;
    assign old    = mem[c_addr];

    always_comb begin
        merged = old;
        ld     = old;
        case (be_eff)
            4'b0011: begin
                merged[15:0]  = c_wd[15:0];
                ld = {{16{c_sign & old[15]}}, old[15:0]};
            end
            4'b1100: begin
                merged[31:16] = c_wd[15:0];
                ld = {{16{c_sign & old[31]}}, old[31:16]};
            end
            4'b0001: begin
                merged[7:0]   = c_wd[7:0];
                ld = {{24{c_sign & old[7]}}, old[7:0]};
            end
            4'b0010: begin
                merged[15:8]  = c_wd[7:0];
                ld = {{24{c_sign & old[15]}}, old[15:8]};
            end
            4'b0100: begin
                merged[23:16] = c_wd[7:0];
                ld = {{24{c_sign & old[23]}}, old[23:16]};
            end
            4'b1000: begin
                merged[31:24] = c_wd[7:0];
                ld = {{24{c_sign & old[31]}}, old[31:24]};
            end
            default: begin
                merged = c_wd;
                ld     = old;
            end
        endcase
    end

    // Gating on Reset keeps an aborted store from committing while reset is held.
    assign we = enter_resp && c_wr && !bad && Reset;

    always_ff @(posedge Clk) begin
        if (we) mem[c_addr] <= merged;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            r_wr   <= 1'b0;
            r_sign <= 1'b0;
            r_addr <= '0;
            r_be   <= 4'd0;
            r_wd   <= 32'd0;
            Rd     <= 32'd0;
`ifdef DM_RESP_ERR_EN
            Err    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == S_IDLE && Req) begin
                r_wr   <= Wr;
                r_sign <= Sign;
                r_addr <= Addr;
                r_be   <= Membe;
                r_wd   <= Wd;
            end
            if (enter_resp) begin
                Rd  <= (c_wr || bad) ? 32'd0 : ld;
`ifdef DM_RESP_ERR_EN
                Err <= bad;
`endif
            end
        end
    end

    assign Ready = (state == S_RESP);
    assign Busy  = (state != S_IDLE);

endmodule
